// File: rtl/decode_fault_stage_pkg.sv
// Shared types for the decode fault stage: decoded instruction, queued entry and stage FSM state.
package decode_fault_stage_pkg;

    localparam int unsigned DEC_XLEN = 64;

    localparam logic [DEC_XLEN-1:0] EXC_ILLEGAL_INSTR = DEC_XLEN'(2);

    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } si_t;

    typedef struct packed {
        si_t                 si;
        logic [DEC_XLEN-1:0] pc;
        logic                ex_valid;
        logic [DEC_XLEN-1:0] cause;
        logic [DEC_XLEN-1:0] tval;
    } dec_entry_t;

    typedef enum logic {
        RUN,
        HALT
    } fault_stage_state_t;

endpackage

// File: rtl/decode_skid_fifo.sv
// DEPTH-entry FIFO of decoded entries; DEPTH must be 2 or 4. Flush clears occupancy, not storage.
module decode_skid_fifo
    import decode_fault_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  dec_entry_t      wdata_i,
    output dec_entry_t      rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    dec_entry_t      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/decode_fault_stage.sv
// Decode-to-issue stage: queues decoded instructions, turns the fault flag into an
// illegal-instruction exception and halts intake after a fault until the backend flushes.
module decode_fault_stage
    import decode_fault_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            si_valid_i,
    output logic            si_ready_o,
    input  si_t             si_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            is_fault_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output si_t             out_si_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            out_ex_valid_o,
    output logic [XLEN-1:0] out_ex_cause_o,
    output logic [XLEN-1:0] out_ex_tval_o,
    output logic            halted_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fault_stage_state_t state_q, state_d;
    dec_entry_t         wr_entry;
    dec_entry_t         head;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CntW-1:0]    fifo_count;

    // rstn is an active-high reset despite its name; ready stays low while it is held.
    assign si_ready_o  = !rstn && (fifo_count < CntW'(DEPTH)) && (state_q == RUN) && !flush_i;
    assign out_valid_o = !fifo_empty;
    assign push        = si_valid_i && si_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        wr_entry          = '0;
        wr_entry.si       = si_i;
        wr_entry.pc       = pc_i;
        wr_entry.ex_valid = is_fault_i;
        if (is_fault_i) begin
            wr_entry.cause = EXC_ILLEGAL_INSTR;
            wr_entry.tval  = {{(XLEN - 32){1'b0}}, instr_i};
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = RUN;
        end else if (push && is_fault_i) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    decode_skid_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_si_o       = head.si;
    assign out_pc_o       = head.pc;
    assign out_ex_valid_o = head.ex_valid;
    assign out_ex_cause_o = head.cause;
    assign out_ex_tval_o  = head.tval;
    assign halted_o       = (state_q == HALT);

    a_no_push_full: assert property (@(posedge clk) disable iff (rstn) !(push && fifo_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rstn) !(pop && fifo_empty));
    a_halt_no_ready: assert property (@(posedge clk) disable iff (rstn)
                                      (state_q == HALT) |-> !si_ready_o);

endmodule
